param_seq_divider: RTL and testbench



---
 rtl/param_seq_divider_pkg.sv | 16 +
 rtl/param_seq_divider_rcs.sv | 48 ++++
 rtl/param_seq_divider.sv | 132 +++++++++++++
 tb/tb_param_seq_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// the iteration-counter width helper.
package param_seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_t;

    // Counter must hold WIDTH-1; a one-bit floor keeps tiny widths legal.
    function automatic int countWidth(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/param_seq_divider_rcs.sv
// Ripple-borrow subtractor (a - b) built from the shared full-adder cell,
// plus the cell itself with its exact/approximate APPROX parameter.
module param_full_adder #(
    parameter int APPROX = 0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign cout = (a & b) | (a & cin) | (b & cin);
    // Approximate cell reuses the carry to form the sum bit.
    assign sum  = (APPROX == 0) ? (a ^ b ^ cin) : ~cout;

endmodule

module param_rcs #(
    parameter int WIDTH  = 9,
    parameter int APPROX = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] carry;

    // a + ~b + 1: every stage is a full adder so the LSB can absorb the +1.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_stage
        param_full_adder #(
            .APPROX(APPROX)
        ) u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/param_seq_divider.sv
// Multi-cycle restoring unsigned divider producing one quotient bit per
// clock, with valid/ready handshakes on both sides.
module param_seq_divider
    import param_seq_divider_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int APPROX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = countWidth(WIDTH);

    divState_t state, nextState;

    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divReg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;
    logic             lastStep;
    logic             unusedTrialTop;

    assign shifted  = {remReg, quoReg[WIDTH-1]};
    assign lastStep = (count == '0);

    param_rcs #(
        .WIDTH (WIDTH + 1),
        .APPROX(APPROX)
    ) u_rcs (
        .a     (shifted),
        .b     ({1'b0, divReg}),
        .diff  (trial),
        .borrow(borrow)
    );

    // A successful trial subtraction always leaves a partial remainder
    // below the divisor, so the top difference bit never needs storing.
    assign nextRem        = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign nextQuo        = {quoReg[WIDTH-2:0], ~borrow};
    assign unusedTrialTop = trial[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nextState = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath only moves on an accept or a CALC step, which leaves it
    // frozen (and clock-gateable) while idle or holding a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remReg      <= '0;
            quoReg      <= '0;
            divReg      <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && (divisor == '0)) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (in_valid) begin
                        remReg <= '0;
                        quoReg <= dividend;
                        divReg <= divisor;
                        count  <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    remReg <= nextRem;
                    quoReg <= nextQuo;
                    count  <= count - CW'(1);
                    if (lastStep) begin
                        quotient    <= nextQuo;
                        remainder   <= nextRem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_seq_divider.sv
// Randomised self-checking bench for param_seq_divider at WIDTH=8 and
// WIDTH=16, compared against plain integer division.
module tb_param_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dividendBus;
    logic [15:0] divisorBus;
    logic        inValid8;
    logic        inValid16;
    logic        outReady;

    logic        inReady8,  outValid8,  dbz8;
    logic [7:0]  quo8,      rem8;
    logic        inReady16, outValid16, dbz16;
    logic [15:0] quo16,     rem16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_seq_divider #(.WIDTH(8), .APPROX(0)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid8),
        .in_ready   (inReady8),
        .dividend   (dividendBus[7:0]),
        .divisor    (divisorBus[7:0]),
        .out_valid  (outValid8),
        .out_ready  (outReady),
        .quotient   (quo8),
        .remainder  (rem8),
        .div_by_zero(dbz8)
    );

    param_seq_divider #(.WIDTH(16), .APPROX(0)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid16),
        .in_ready   (inReady16),
        .dividend   (dividendBus),
        .divisor    (divisorBus),
        .out_valid  (outValid16),
        .out_ready  (outReady),
        .quotient   (quo16),
        .remainder  (rem16),
        .div_by_zero(dbz16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: ordinary integer division; divide-by-zero saturates.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z);
        logic [15:0] mask;
        mask = (w == 8) ? 16'h00FF : 16'hFFFF;
        if (b == 16'd0) begin
            q = mask;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    function automatic logic [15:0] obsQuo(input int w);
        return (w == 8) ? {8'd0, quo8} : quo16;
    endfunction

    function automatic logic [15:0] obsRem(input int w);
        return (w == 8) ? {8'd0, rem8} : rem16;
    endfunction

    function automatic logic obsDbz(input int w);
        return (w == 8) ? dbz8 : dbz16;
    endfunction

    function automatic logic obsValid(input int w);
        return (w == 8) ? outValid8 : outValid16;
    endfunction

    function automatic logic obsReady(input int w);
        return (w == 8) ? inReady8 : inReady16;
    endfunction

    task automatic setValid(input int w, input logic v);
        if (w == 8) inValid8 = v;
        else        inValid16 = v;
    endtask

    // One full operation: accept, noisy inputs while busy, stall, release.
    task automatic applyStimulus(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input int stall);
        logic [15:0] expQ, expR;
        logic        expZ;
        int          edges;
        int          expLat;
        model(w, a, b, expQ, expR, expZ);
        expLat = (b == 16'd0) ? 0 : w;

        @(negedge clk);
        checkOutput("idleReady", 32'(obsReady(w)), 32'd1);
        dividendBus = a;
        divisorBus  = b;
        setValid(w, 1'b1);
        outReady    = 1'b0;
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        while (!obsValid(w) && edges < 100) begin
            checkOutput("busyReady", 32'(obsReady(w)), 32'd0);
            setValid(w, 1'($urandom_range(0, 1)));
            dividendBus = 16'($urandom);
            divisorBus  = 16'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", 32'(edges), 32'(expLat));
        checkOutput("quotient", 32'(obsQuo(w)), 32'(expQ));
        checkOutput("remainder", 32'(obsRem(w)), 32'(expR));
        checkOutput("divByZero", 32'(obsDbz(w)), 32'(expZ));
        if (b != 16'd0) begin
            checkOutput("invariant", 32'(obsQuo(w)) * 32'(b) + 32'(obsRem(w)), 32'(a));
            checkOutput("remBelowDivisor", 32'(obsRem(w) < b), 32'd1);
        end

        for (int i = 0; i < stall; i++) begin
            setValid(w, 1'b1);
            dividendBus = 16'($urandom);
            divisorBus  = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("holdValid", 32'(obsValid(w)), 32'd1);
            checkOutput("holdReady", 32'(obsReady(w)), 32'd0);
            checkOutput("holdQuotient", 32'(obsQuo(w)), 32'(expQ));
            checkOutput("holdRemainder", 32'(obsRem(w)), 32'(expR));
        end

        setValid(w, 1'b0);
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("releaseValid", 32'(obsValid(w)), 32'd0);
        checkOutput("releaseReady", 32'(obsReady(w)), 32'd1);
        checkOutput("keepQuotient", 32'(obsQuo(w)), 32'(expQ));
        checkOutput("keepRemainder", 32'(obsRem(w)), 32'(expR));
    endtask

    initial begin
        logic [15:0] a, b;
        rst         = 1'b1;
        dividendBus = '0;
        divisorBus  = '0;
        inValid8    = 1'b0;
        inValid16   = 1'b0;
        outReady    = 1'b0;
        #1;
        checkOutput("resetReady", 32'(inReady8), 32'd1);
        checkOutput("resetValid", 32'(outValid8), 32'd0);
        checkOutput("resetQuotient", 32'(quo8), 32'd0);
        checkOutput("resetRemainder", 32'(rem8), 32'd0);
        checkOutput("resetDbz", 32'(dbz8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8, 16'd200, 16'd7, 0);
        applyStimulus(8, 16'd5, 16'd9, 0);
        applyStimulus(8, 16'd255, 16'd1, 1);
        applyStimulus(8, 16'd255, 16'd255, 0);
        applyStimulus(8, 16'd77, 16'd0, 2);
        applyStimulus(8, 16'd10, 16'd3, 0);
        applyStimulus(8, 16'd100, 16'd9, 5);

        // Abort an operation part-way through the iteration.
        @(negedge clk);
        dividendBus = 16'd250;
        divisorBus  = 16'd3;
        inValid8    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetReady", 32'(inReady8), 32'd1);
        checkOutput("midResetValid", 32'(outValid8), 32'd0);
        checkOutput("midResetQuotient", 32'(quo8), 32'd0);
        checkOutput("midResetRemainder", 32'(rem8), 32'd0);
        checkOutput("midResetDbz", 32'(dbz8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postResetValid", 32'(outValid8), 32'd0);
        applyStimulus(8, 16'd250, 16'd3, 0);

        for (int n = 0; n < 2000; n++) begin
            a = 16'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
            applyStimulus(8, a, b, $urandom_range(0, 3));
        end
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            applyStimulus(16, a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
